// File: rtl/mac_table_pkg.sv
// Shared constants and encodings for the destination-MAC table manager.
// MAC_TABLE_AGING_EN adds the AGE_SCAN state.
package mac_table_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int IDX_W       = 5;
  localparam int MCAST_BIT   = 0;

  typedef logic [47:0]      mac_t;
  typedef logic [7:0]       port_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_DELETE = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_RSVD   = 2'd3
  } cfg_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CFG_WR  = 3'd1,
    S_LRN_CMP = 3'd2,
`ifdef MAC_TABLE_AGING_EN
    S_LRN_WR  = 3'd3,
    S_AGE_SCAN = 3'd4
`else
    S_LRN_WR  = 3'd3
`endif
  } state_e;

endpackage

// File: rtl/mac_table_if.sv
// Host-config and learn request channels of the MAC table manager.
// The master side issues requests; the table manager is the slave.
interface mac_table_if;
  import mac_table_pkg::*;

  logic  cfg_valid;
  logic  cfg_ready;
  logic  [1:0] cfg_op;
  idx_t  cfg_idx;
  mac_t  cfg_mac;
  port_t cfg_port;
  logic  cfg_done;

  logic  learn_valid;
  logic  learn_ready;
  mac_t  learn_mac;
  port_t learn_port;
  logic  learn_drop;

  modport master (
    output cfg_valid, cfg_op, cfg_idx,
    output cfg_mac, cfg_port,
    output learn_valid, learn_mac, learn_port,
    input  cfg_ready, cfg_done,
    input  learn_ready, learn_drop
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_idx,
    input  cfg_mac, cfg_port,
    input  learn_valid, learn_mac, learn_port,
    output cfg_ready, cfg_done,
    output learn_ready, learn_drop
  );

endinterface

// File: rtl/mac_table_match.sv
// Parallel MAC hit vector and lowest-free-slot encoder over the table.
// Purely combinational; the caller registers the results.
module mac_table_match
  import mac_table_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0] valid,
  input  mac_t [NUM_ENTRIES-1:0] mac,
  input  mac_t                   key,
  output logic [NUM_ENTRIES-1:0] hit,
  output logic                   free_any,
  output idx_t                   free_idx
);

  always_comb begin
    hit      = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      hit[i] = valid[i] && (mac[i] == key);
    // Descending scan so the lowest free index wins.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/mac_table_manager.sv
// 32-entry destination MAC table with host config and source learning.
// Define MAC_TABLE_AGING_EN to age out dynamic entries.
module mac_table_manager
  import mac_table_pkg::*;
`ifdef MAC_TABLE_AGING_EN
#(
  parameter logic [31:0] AGE_TICK_CYCLES = 32'd156250000,
  parameter logic [1:0]  AGE_MAX         = 2'd3
)
`endif
(
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  mac_table_if.slave               bus,
  output logic [NUM_ENTRIES*48-1:0] tbl_mac,
  output logic [NUM_ENTRIES*8-1:0]  tbl_port,
  output logic [IDX_W:0]            tbl_count
);

  state_e state_q, state_d;

  logic  [NUM_ENTRIES-1:0] valid_q;
  logic  [NUM_ENTRIES-1:0] static_q;
  mac_t  [NUM_ENTRIES-1:0] mac_q;
  port_t [NUM_ENTRIES-1:0] port_q;
  cnt_t                    count_q;

  cfg_op_e op_q;
  idx_t    idx_q;
  mac_t    req_mac_q;
  port_t   req_port_q;

  logic [NUM_ENTRIES-1:0] hit, hit_q;
  logic                   free_any, free_any_q;
  idx_t                   free_idx, free_idx_q;

`ifdef MAC_TABLE_AGING_EN
  logic [NUM_ENTRIES-1:0][1:0] age_q;
  logic [31:0] tick_q;
  logic        age_pend_q;
  idx_t        scan_idx_q;
`endif

  mac_table_match u_match (
    .valid    (valid_q),
    .mac      (mac_q),
    .key      (req_mac_q),
    .hit      (hit),
    .free_any (free_any),
    .free_idx (free_idx)
  );

  assign bus.cfg_ready   = (state_q == S_IDLE);
  assign bus.learn_ready = (state_q == S_IDLE) && !bus.cfg_valid;
  assign bus.cfg_done    = (state_q == S_CFG_WR);
  assign bus.learn_drop  = (state_q == S_LRN_WR) &&
                           (hit_q == '0) && !free_any_q;

  // Invalid entries hold mac/port at zero, so the arrays are the outputs.
  assign tbl_mac   = mac_q;
  assign tbl_port  = port_q;
  assign tbl_count = count_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid)        state_d = S_CFG_WR;
        else if (bus.learn_valid) state_d = S_LRN_CMP;
`ifdef MAC_TABLE_AGING_EN
        else if (age_pend_q)      state_d = S_AGE_SCAN;
`endif
      end
      S_CFG_WR:  state_d = S_IDLE;
      S_LRN_CMP: state_d = req_mac_q[MCAST_BIT] ? S_IDLE : S_LRN_WR;
      S_LRN_WR:  state_d = S_IDLE;
`ifdef MAC_TABLE_AGING_EN
      S_AGE_SCAN:
        if (scan_idx_q == idx_t'(NUM_ENTRIES - 1)) state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      valid_q    <= '0;
      static_q   <= '0;
      mac_q      <= '0;
      port_q     <= '0;
      count_q    <= '0;
      op_q       <= OP_WRITE;
      idx_q      <= '0;
      req_mac_q  <= '0;
      req_port_q <= '0;
      hit_q      <= '0;
      free_any_q <= 1'b0;
      free_idx_q <= '0;
`ifdef MAC_TABLE_AGING_EN
      age_q      <= '0;
      scan_idx_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            op_q       <= cfg_op_e'(bus.cfg_op);
            idx_q      <= bus.cfg_idx;
            req_mac_q  <= bus.cfg_mac;
            req_port_q <= bus.cfg_port;
          end else if (bus.learn_valid) begin
            req_mac_q  <= bus.learn_mac;
            req_port_q <= bus.learn_port;
          end
        end
        S_CFG_WR: begin
          case (op_q)
            OP_WRITE: begin
              valid_q[idx_q]  <= 1'b1;
              static_q[idx_q] <= 1'b1;
              mac_q[idx_q]    <= req_mac_q;
              port_q[idx_q]   <= req_port_q;
`ifdef MAC_TABLE_AGING_EN
              age_q[idx_q]    <= '0;
`endif
              if (!valid_q[idx_q]) count_q <= count_q + cnt_t'(1);
            end
            OP_DELETE: begin
              if (valid_q[idx_q]) begin
                valid_q[idx_q]  <= 1'b0;
                static_q[idx_q] <= 1'b0;
                mac_q[idx_q]    <= '0;
                port_q[idx_q]   <= '0;
                count_q         <= count_q - cnt_t'(1);
              end
            end
            OP_CLEAR: begin
              valid_q  <= '0;
              static_q <= '0;
              mac_q    <= '0;
              port_q   <= '0;
              count_q  <= '0;
            end
            default: ;
          endcase
        end
        S_LRN_CMP: begin
          hit_q      <= hit;
          free_any_q <= free_any;
          free_idx_q <= free_idx;
        end
        S_LRN_WR: begin
          if (|hit_q) begin
            // A static hit pins the entry; otherwise it is a station move.
            if (~|(hit_q & static_q)) begin
              for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (hit_q[i]) begin
                  port_q[i] <= req_port_q;
`ifdef MAC_TABLE_AGING_EN
                  age_q[i]  <= '0;
`endif
                end
              end
            end
          end else if (free_any_q) begin
            valid_q[free_idx_q]  <= 1'b1;
            static_q[free_idx_q] <= 1'b0;
            mac_q[free_idx_q]    <= req_mac_q;
            port_q[free_idx_q]   <= req_port_q;
`ifdef MAC_TABLE_AGING_EN
            age_q[free_idx_q]    <= '0;
`endif
            count_q <= count_q + cnt_t'(1);
          end
        end
`ifdef MAC_TABLE_AGING_EN
        S_AGE_SCAN: begin
          if (valid_q[scan_idx_q] && !static_q[scan_idx_q]) begin
            if (age_q[scan_idx_q] == AGE_MAX) begin
              valid_q[scan_idx_q] <= 1'b0;
              mac_q[scan_idx_q]   <= '0;
              port_q[scan_idx_q]  <= '0;
              age_q[scan_idx_q]   <= '0;
              count_q <= count_q - cnt_t'(1);
            end else begin
              age_q[scan_idx_q] <= age_q[scan_idx_q] + 2'd1;
            end
          end
          scan_idx_q <= scan_idx_q + idx_t'(1);
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef MAC_TABLE_AGING_EN
  // A wrap on the scan-entry cycle keeps the pending flag so no tick is lost.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      tick_q     <= '0;
      age_pend_q <= 1'b0;
    end else begin
      if (tick_q == AGE_TICK_CYCLES - 32'd1) begin
        tick_q     <= '0;
        age_pend_q <= 1'b1;
      end else begin
        tick_q <= tick_q + 32'd1;
        if (state_q == S_IDLE && state_d == S_AGE_SCAN)
          age_pend_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_table_manager.sv
// Directed bench for mac_table_manager with hand-computed expectations.
// With MAC_TABLE_AGING_EN a second instance exercises aging and async reset.
module tb_mac_table_manager;
  import mac_table_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;

  logic [NUM_ENTRIES*48-1:0] tbl_mac;
  logic [NUM_ENTRIES*8-1:0]  tbl_port;
  logic [IDX_W:0]            tbl_count;

  mac_table_if bus();

  mac_table_manager dut (
    .axis_aclk   (clk),
    .axis_resetn (rst_n),
    .bus         (bus.slave),
    .tbl_mac     (tbl_mac),
    .tbl_port    (tbl_port),
    .tbl_count   (tbl_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mac_at(input int i);
    return tbl_mac[48*i +: 48];
  endfunction

  function automatic logic [7:0] port_at(input int i);
    return tbl_port[8*i +: 8];
  endfunction

  function automatic logic [47:0] mk(input int k);
    return 48'h0000_0000_0002 | (48'(k) << 16);
  endfunction

  task automatic cfg_req(input logic [1:0] op, input int idx,
                         input logic [47:0] m, input logic [7:0] p);
    int t;
    t = 0;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = op;
    bus.cfg_idx   = idx_t'(idx);
    bus.cfg_mac   = m;
    bus.cfg_port  = p;
    while (!bus.cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("cfg_hs_timeout", 64'(t), 0);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
    check("cfg_done_pulse", 64'(bus.cfg_done), 1);
    @(posedge clk);
    #1 check("cfg_done_low", 64'(bus.cfg_done), 0);
  endtask

  task automatic learn_req(input logic [47:0] m, input logic [7:0] p,
                           output logic drop, output logic [IDX_W:0] pre);
    int t;
    t = 0;
    @(negedge clk);
    bus.learn_valid = 1'b1;
    bus.learn_mac   = m;
    bus.learn_port  = p;
    while (!bus.learn_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("learn_hs_timeout", 64'(t), 0);
    @(posedge clk);
    #1 bus.learn_valid = 1'b0;
    @(posedge clk);
    #1 drop = bus.learn_drop;
    pre = tbl_count;
    @(posedge clk);
    #1;
  endtask

`ifdef MAC_TABLE_AGING_EN
  logic rst2_n;
  logic [NUM_ENTRIES*48-1:0] tbl_mac2;
  logic [NUM_ENTRIES*8-1:0]  tbl_port2;
  logic [IDX_W:0]            tbl_count2;

  mac_table_if bus2();

  mac_table_manager #(.AGE_TICK_CYCLES(32'd16), .AGE_MAX(2'd3)) dut_age (
    .axis_aclk   (clk),
    .axis_resetn (rst2_n),
    .bus         (bus2.slave),
    .tbl_mac     (tbl_mac2),
    .tbl_port    (tbl_port2),
    .tbl_count   (tbl_count2)
  );

  task automatic age_test();
    int t;
    int t0;
    t = 0;
    @(negedge clk);
    bus2.cfg_valid = 1'b1;
    bus2.cfg_op    = OP_WRITE;
    bus2.cfg_idx   = 5'd1;
    bus2.cfg_mac   = 48'h0000_5E00_0102;
    bus2.cfg_port  = 8'h02;
    while (!bus2.cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 bus2.cfg_valid = 1'b0;
    t = 0;
    @(negedge clk);
    bus2.learn_valid = 1'b1;
    bus2.learn_mac   = 48'h0A11_2233_4400;
    bus2.learn_port  = 8'h01;
    while (!bus2.learn_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 bus2.learn_valid = 1'b0;
    t0 = cyc;
    repeat (3) @(posedge clk);
    #1 check("age_pre_count", 64'(tbl_count2), 2);
    t = 0;
    while (tbl_count2 != 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (tbl_count2 == 2 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("age_expire_timeout", 64'(t < 400), 1);
    check("age_not_early", 64'((cyc - t0) >= 90), 1);
    check("age_not_late", 64'((cyc - t0) <= 200), 1);
    check("age_count", 64'(tbl_count2), 1);
    check("age_dyn_gone", 64'(tbl_mac2[0 +: 48]), 0);
    check("age_static_mac", 64'(tbl_mac2[48 +: 48]), 64'h0000_5E00_0102);
    check("age_static_port", 64'(tbl_port2[8 +: 8]), 8'h02);
    repeat (10) @(posedge clk);
    #3 rst2_n = 1'b0;
    #1 check("age_async_count", 64'(tbl_count2), 0);
    check("age_async_mac", 64'(|tbl_mac2), 0);
    check("age_async_port", 64'(|tbl_port2), 0);
    @(negedge clk);
    rst2_n = 1'b1;
  endtask
`endif

  initial begin
    logic drop;
    logic [IDX_W:0] pre;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_op      = '0;
    bus.cfg_idx     = '0;
    bus.cfg_mac     = '0;
    bus.cfg_port    = '0;
    bus.learn_valid = 1'b0;
    bus.learn_mac   = '0;
    bus.learn_port  = '0;
`ifdef MAC_TABLE_AGING_EN
    rst2_n = 1'b0;
    bus2.cfg_valid   = 1'b0;
    bus2.cfg_op      = '0;
    bus2.cfg_idx     = '0;
    bus2.cfg_mac     = '0;
    bus2.cfg_port    = '0;
    bus2.learn_valid = 1'b0;
    bus2.learn_mac   = '0;
    bus2.learn_port  = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
`ifdef MAC_TABLE_AGING_EN
    rst2_n = 1'b1;
`endif
    @(negedge clk);
    check("rst_count", 64'(tbl_count), 0);
    check("rst_mac", 64'(|tbl_mac), 0);
    check("rst_port", 64'(|tbl_port), 0);
    check("rst_cfg_ready", 64'(bus.cfg_ready), 1);
    check("rst_learn_ready", 64'(bus.learn_ready), 1);
    check("rst_cfg_done", 64'(bus.cfg_done), 0);
    check("rst_learn_drop", 64'(bus.learn_drop), 0);

    cfg_req(OP_WRITE, 3, 48'h0000_5E00_0102, 8'h04);
    check("wr_mac3", 64'(mac_at(3)), 64'h0000_5E00_0102);
    check("wr_port3", 64'(port_at(3)), 8'h04);
    check("wr_count", 64'(tbl_count), 1);

    learn_req(48'h0A11_2233_4400, 8'h01, drop, pre);
    check("lrn_pre_count", 64'(pre), 1);
    check("lrn_drop", 64'(drop), 0);
    check("lrn_mac0", 64'(mac_at(0)), 64'h0A11_2233_4400);
    check("lrn_port0", 64'(port_at(0)), 8'h01);
    check("lrn_count", 64'(tbl_count), 2);

    learn_req(48'h0A11_2233_4400, 8'h10, drop, pre);
    check("move_port0", 64'(port_at(0)), 8'h10);
    check("move_count", 64'(tbl_count), 2);
    check("move_mac1", 64'(mac_at(1)), 0);

    learn_req(48'h0000_5E00_0102, 8'h01, drop, pre);
    check("static_port3", 64'(port_at(3)), 8'h04);
    check("static_count", 64'(tbl_count), 2);

    learn_req(48'h0A11_2233_4401, 8'h01, drop, pre);
    check("mcast_drop", 64'(drop), 0);
    check("mcast_count", 64'(tbl_count), 2);
    check("mcast_mac1", 64'(mac_at(1)), 0);

    for (int k = 0; k < 30; k++) learn_req(mk(k), 8'h02, drop, pre);
    check("fill_count", 64'(tbl_count), 32);
    check("fill_mac1", 64'(mac_at(1)), 64'(mk(0)));
    check("fill_mac4", 64'(mac_at(4)), 64'(mk(2)));
    check("fill_mac31", 64'(mac_at(31)), 64'(mk(29)));

    learn_req(48'h0000_00AB_CD00, 8'h08, drop, pre);
    check("full_drop", 64'(drop), 1);
    check("full_drop_once", 64'(bus.learn_drop), 0);
    check("full_count", 64'(tbl_count), 32);
    check("full_port0", 64'(port_at(0)), 8'h10);

    @(negedge clk);
    bus.cfg_valid   = 1'b1;
    bus.cfg_op      = OP_DELETE;
    bus.cfg_idx     = 5'd5;
    bus.learn_valid = 1'b1;
    bus.learn_mac   = 48'h0000_0000_BE00;
    bus.learn_port  = 8'h20;
    #1 check("arb_lrdy_low", 64'(bus.learn_ready), 0);
    check("arb_crdy_high", 64'(bus.cfg_ready), 1);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
    check("arb_cfg_first", 64'(bus.cfg_done), 1);
    check("arb_lrdy_busy", 64'(bus.learn_ready), 0);
    @(posedge clk);
    #1 check("arb_del_mac5", 64'(mac_at(5)), 0);
    check("arb_del_count", 64'(tbl_count), 31);
    check("arb_lrdy_idle", 64'(bus.learn_ready), 1);
    @(posedge clk);
    #1 bus.learn_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("arb_lrn_mac5", 64'(mac_at(5)), 64'h0000_0000_BE00);
    check("arb_lrn_port5", 64'(port_at(5)), 8'h20);
    check("arb_lrn_count", 64'(tbl_count), 32);

    cfg_req(OP_CLEAR, 0, 48'h0, 8'h0);
    check("clr_count", 64'(tbl_count), 0);
    check("clr_mac", 64'(|tbl_mac), 0);
    check("clr_port", 64'(|tbl_port), 0);

    cfg_req(OP_RSVD, 7, 48'h0000_1111_2200, 8'h01);
    check("rsvd_count", 64'(tbl_count), 0);
    check("rsvd_mac7", 64'(mac_at(7)), 0);

`ifdef MAC_TABLE_AGING_EN
    age_test();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_table_manager.md
Name: mac_table_manager

Overview:
- Owns the 32-entry destination-MAC/port table that feeds the switch's output-port lookup stage through its flat dst_mac_N/dst_port_N inputs.
- Arbitrates between two request sources: host configuration (static entries) and datapath source-MAC learning (dynamic entries).
- Optionally ages out dynamic entries.
- Every table change goes through a single sequencing FSM, so the lookup always sees a coherent table.

Parameters:
- NUM_ENTRIES, 32, table depth; fixed to match the lookup stage.
- IDX_W, 5, index width, log2(NUM_ENTRIES).
- AGE_TICK_CYCLES, 32'd156250000, clock cycles per aging tick.
- AGE_MAX, 3, number of ticks a dynamic entry survives without a refresh.

Ports:
- axis_aclk  in  1  clock
- axis_resetn  in  1  asynchronous active-low reset
- cfg_valid  in  1  host request valid
- cfg_ready  out  1  host request accepted when cfg_valid&&cfg_ready
- cfg_op  in  2  0=WRITE static, 1=DELETE, 2=CLEAR all, 3=reserved (treated as no-op, still returns cfg_done)
- cfg_idx  in  IDX_W  target entry
- cfg_mac  in  48  MAC, same byte order as the lookup (first wire byte in [7:0])
- cfg_port  in  8  one-hot/bitmap destination port
- cfg_done  out  1  one-cycle completion pulse
- learn_valid  in  1  learn request (src MAC + ingress port, one per packet SOP)
- learn_ready  out  1  learn request accepted
- learn_mac  in  48  source MAC
- learn_port  in  8  ingress port bitmap
- learn_drop  out  1  one-cycle pulse: table full, request discarded
- tbl_mac  out  NUM_ENTRIES*48  entry i at [48*i+47:48*i]
- tbl_port  out  NUM_ENTRIES*8  entry i at [8*i+7:8*i]
- tbl_count  out  IDX_W+1  number of valid entries

Behaviour:
- Per-entry state: valid, static, mac, port, age (2b). Reset clears all of it; all outputs reset to 0.
- Invalid entries drive mac=0, port=0 on tbl_*. tbl_* are registered, so an update is visible the cycle after its write.
- FSM states: IDLE, CFG_WR, LRN_CMP, LRN_WR, AGE_SCAN.
- cfg_ready = (state==IDLE).
- learn_ready = (state==IDLE) && !cfg_valid. Host has priority over learning; learning has priority over aging.
- IDLE -> CFG_WR on a cfg handshake. CFG_WR executes the op and pulses cfg_done, then returns to IDLE. Total 2 cycles.
  - WRITE: sets valid=1, static=1, mac, port, age=0 at cfg_idx.
  - DELETE: sets valid=0 at cfg_idx.
  - CLEAR: invalidates every entry, static ones included.
- IDLE -> LRN_CMP on a learn handshake.
  - Request is latched. Multicast source (learn_mac[0]==1) is discarded silently: back to IDLE, no drop pulse.
  - LRN_CMP registers a parallel hit vector over valid entries, plus the lowest free index.
- LRN_WR actions:
  - Hit on a static entry: no change.
  - Hit on a dynamic entry: port=learn_port (station move), age=0.
  - Miss with a free slot: allocate the lowest free index, static=0, age=0.
  - Miss with no free slot: pulse learn_drop.
  - Then return to IDLE. Total 3 cycles from handshake to table write.
- Duplicate MACs:
  - Learning never creates a duplicate, because the hit check runs first.
  - Host WRITE may create a duplicate. The lookup then resolves it by lowest index; this is not an error.
- tbl_count is updated in the same cycle as the entry write.
- Reset mid-operation: the FSM returns to IDLE and pending requests are lost. Requesters must re-issue after reset.

Optional Feature:
- Macro: MAC_TABLE_AGING_EN.
- Defined:
  - A free-running tick counter wraps at AGE_TICK_CYCLES-1. Each wrap sets age_pend. A tick that arrives while age_pend is already set is merged.
  - IDLE with no cfg/learn request and age_pend=1 -> AGE_SCAN; age_pend is cleared on entry.
  - AGE_SCAN visits index 0..NUM_ENTRIES-1, one entry per cycle, and cannot be pre-empted (NUM_ENTRIES cycles).
  - For each valid dynamic entry: if age==AGE_MAX, invalidate it; else age++.
  - Static entries are untouched.
- Undefined: no counter, no AGE_SCAN state, and dynamic entries persist until DELETE/CLEAR.

Decomposition:
- Package mac_table_pkg holds:
  - cfg_op encodings (OP_WRITE, OP_DELETE, OP_CLEAR);
  - FSM state encodings;
  - the NUM_ENTRIES/IDX_W constants;
  - the MAC multicast-bit position.
- One sub-module, mac_table_match: combinational hit vector plus lowest-free priority encoder over the entry arrays. It is reused by LRN_CMP.

Test Plan:
- Host WRITE idx=3, mac=48'h0000_5E00_0102, port=8'h04 -> cfg_done 1 cycle after handshake; tbl_mac[3]/tbl_port[3] show the values next cycle; tbl_count=1.
- Learn mac=48'h0A_11_22_33_44_00, port=8'h01 into an empty table -> entry 0 written 3 cycles after handshake. Relearn with port 8'h10 -> entry 0 port becomes 8'h10, tbl_count unchanged.
- Learn the MAC that is static at idx 3 with port 8'h01 -> entry 3 port stays 8'h04. Learn mac[0]=1 -> no change, no learn_drop.
- Fill all 32 entries, then learn a new MAC -> learn_drop pulses once; table unchanged.
- cfg_valid and learn_valid asserted in the same cycle -> host accepted first; learn accepted after cfg_done. Then CLEAR -> all tbl_* =0, tbl_count=0.
- MAC_TABLE_AGING_EN, AGE_TICK_CYCLES=16 -> a dynamic entry not refreshed is invalidated after its 4th scan (AGE_MAX=3); a static entry remains; asserting axis_resetn=0 mid-scan clears everything asynchronously.
